// File: rtl/dll_pkg.sv
// Shared widths and enumerations for the DLL transmit scheduler slice.
package dll_pkg;
  localparam int DLLP_W = 48;
  localparam int TLP_W  = 1196;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DLLP,
    GNT_TLP
  } tx_grant_t;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_t;
endpackage

// File: rtl/dll_tx_scheduler_if.sv
// Requester and PHY-side handshake bundle of the DLL transmit scheduler.
// slave = scheduler side, master = environment (requesters and PHY).
interface dll_tx_scheduler_if;
  import dll_pkg::*;

  logic [DLLP_W-1:0] dllp_i;
  logic              dllp_valid_i;
  logic              dllp_ready_o;
  logic [TLP_W-1:0]  tlp_i;
  logic              tlp_valid_i;
  logic              tlp_ready_o;
  logic              tlp_block_i;
  logic [TLP_W-1:0]  tx_data_o;
  logic              tx_is_dllp_o;
  logic              tx_valid_o;
  logic              tx_ready_i;

  modport slave (
    input  dllp_i, dllp_valid_i, tlp_i, tlp_valid_i, tlp_block_i, tx_ready_i,
    output dllp_ready_o, tlp_ready_o, tx_data_o, tx_is_dllp_o, tx_valid_o
  );

  modport master (
    output dllp_i, dllp_valid_i, tlp_i, tlp_valid_i, tlp_block_i, tx_ready_i,
    input  dllp_ready_o, tlp_ready_o, tx_data_o, tx_is_dllp_o, tx_valid_o
  );
endinterface

// File: rtl/dll_tx_slot.sv
// Single-entry PHY-facing output register. The slot is free when empty or
// when its current content is taken this cycle, so a new entry can be loaded
// back-to-back without a bubble.
module dll_tx_slot
  import dll_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [TLP_W-1:0] i_data,
  input  logic             i_is_dllp,
  input  logic             i_ready,
  output logic             o_free,
  output logic             o_valid,
  output logic [TLP_W-1:0] o_data,
  output logic             o_is_dllp
);
  slot_state_t      r_state;
  slot_state_t      w_state_nxt;
  logic             w_free;
  logic [TLP_W-1:0] r_data;
  logic             r_is_dllp;

  // Slot occupancy register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= SLOT_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Occupancy next-state and free indication.
  always_comb begin
    w_state_nxt = r_state;
    w_free      = 1'b0;
    case (r_state)
      SLOT_EMPTY: begin
        w_free = 1'b1;
        if (i_load) w_state_nxt = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (i_ready) begin
          w_free      = 1'b1;
          w_state_nxt = i_load ? SLOT_FULL : SLOT_EMPTY;
        end
      end
      default: w_state_nxt = SLOT_EMPTY;
    endcase
  end

  // Payload capture; payload is left untouched when the slot drains empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_is_dllp <= 1'b0;
    end else if (i_load && w_free) begin
      r_data    <= i_data;
      r_is_dllp <= i_is_dllp;
    end
  end

  assign o_free    = w_free;
  assign o_valid   = (r_state == SLOT_FULL);
  assign o_data    = r_data;
  assign o_is_dllp = r_is_dllp;
endmodule

// File: rtl/dll_tx_scheduler.sv
// DLL transmit scheduler: arbitrates the single PHY TX slot between DLLPs
// (default winner) and TLPs, with a starvation guard that forces a TLP after
// MAX_DLLP_STREAK consecutive DLLP grants while a TLP is eligible.
// Optional grant statistics: define DLL_TX_SCHED_STATS_EN.
module dll_tx_scheduler
  import dll_pkg::*;
#(
  parameter int MAX_DLLP_STREAK = 4,
  parameter int STAT_W          = 32
) (
  input  logic clk,
  input  logic rst,
  dll_tx_scheduler_if.slave bus
`ifdef DLL_TX_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_dllp_o,
  output logic [STAT_W-1:0] stat_tlp_o,
  output logic [STAT_W-1:0] stat_force_o
`endif
);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DLLP_STREAK);

  if (MAX_DLLP_STREAK < 1 || MAX_DLLP_STREAK > 15 || STAT_W < 1) begin : g_bad_param
    $error("dll_tx_scheduler: parameter out of range");
  end

  logic             w_free;
  logic             w_tlp_ok;
  logic             w_force;
  tx_grant_t        w_grant;
  logic             w_load;
  logic [TLP_W-1:0] w_load_data;
  logic [3:0]       r_streak;

  // Grant decision; nothing is granted while the slot is busy or in reset.
  always_comb begin
    w_tlp_ok = bus.tlp_valid_i && !bus.tlp_block_i;
    w_force  = w_tlp_ok && (r_streak == STREAK_MAX);
    w_grant  = GNT_NONE;
    if (w_free && !rst) begin
      if (w_force)               w_grant = GNT_TLP;
      else if (bus.dllp_valid_i) w_grant = GNT_DLLP;
      else if (w_tlp_ok)         w_grant = GNT_TLP;
    end
  end

  assign bus.dllp_ready_o = (w_grant == GNT_DLLP);
  assign bus.tlp_ready_o  = (w_grant == GNT_TLP);
  assign w_load           = (w_grant != GNT_NONE);
  assign w_load_data      = (w_grant == GNT_DLLP) ?
                            {{(TLP_W-DLLP_W){1'b0}}, bus.dllp_i} : bus.tlp_i;

  // Consecutive DLLP grants taken while a TLP was eligible (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else begin
      case (w_grant)
        GNT_DLLP: r_streak <= w_tlp_ok ?
                              ((r_streak == STREAK_MAX) ? STREAK_MAX : r_streak + 4'd1) : 4'd0;
        GNT_TLP:  r_streak <= 4'd0;
        default:  r_streak <= r_streak;
      endcase
    end
  end

  dll_tx_slot u_slot (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_data    (w_load_data),
    .i_is_dllp (w_grant == GNT_DLLP),
    .i_ready   (bus.tx_ready_i),
    .o_free    (w_free),
    .o_valid   (bus.tx_valid_o),
    .o_data    (bus.tx_data_o),
    .o_is_dllp (bus.tx_is_dllp_o)
  );

`ifdef DLL_TX_SCHED_STATS_EN
  logic [STAT_W-1:0] r_stat_dllp;
  logic [STAT_W-1:0] r_stat_tlp;
  logic [STAT_W-1:0] r_stat_force;

  // Free-running grant counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_dllp  <= '0;
      r_stat_tlp   <= '0;
      r_stat_force <= '0;
    end else begin
      if (w_grant == GNT_DLLP)            r_stat_dllp  <= r_stat_dllp + 1'b1;
      if (w_grant == GNT_TLP)             r_stat_tlp   <= r_stat_tlp + 1'b1;
      if (w_grant == GNT_TLP && w_force)  r_stat_force <= r_stat_force + 1'b1;
    end
  end

  assign stat_dllp_o  = r_stat_dllp;
  assign stat_tlp_o   = r_stat_tlp;
  assign stat_force_o = r_stat_force;
`endif
endmodule

// File: tb/tb_dll_tx_scheduler.sv
// Bench for dll_tx_scheduler: directed scenarios plus random traffic, with a
// reference model feeding an expected-transfer queue that a separate monitor
// drains on every PHY handshake.
module tb_dll_tx_scheduler;
  import dll_pkg::*;

  localparam int MAX = 4;

  typedef struct {
    logic [TLP_W-1:0] data;
    logic             is_dllp;
  } xfer_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  dll_tx_scheduler_if bus ();

`ifdef DLL_TX_SCHED_STATS_EN
  logic [31:0] stat_dllp, stat_tlp, stat_force;
`endif

  dll_tx_scheduler #(.MAX_DLLP_STREAK(MAX), .STAT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef DLL_TX_SCHED_STATS_EN
    ,
    .stat_dllp_o  (stat_dllp),
    .stat_tlp_o   (stat_tlp),
    .stat_force_o (stat_force)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state.
  xfer_t exp_q[$];
  bit    m_full;
  int    m_streak;
  bit    acc_d, acc_t;
  int    dut_g;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic chk_w(input string nm, input logic [TLP_W-1:0] a, input logic [TLP_W-1:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s act_lo=%h exp_lo=%h", nm, a[63:0], e[63:0]);
    end
  endtask

  task automatic chk_s(input string nm, input string a, input string e);
    n_chk++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s act=%s exp=%s", nm, a, e);
    end
  endtask

  function automatic logic [TLP_W-1:0] rand_tlp();
    logic [1215:0] t;
    for (int k = 0; k < 38; k++) t[k*32 +: 32] = $urandom;
    return t[TLP_W-1:0];
  endfunction

  function automatic logic [DLLP_W-1:0] rand_dllp();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DLLP_W-1:0];
  endfunction

  function automatic string gch(input int g);
    if (g == 1) return "D";
    if (g == 2) return "T";
    return "-";
  endfunction

  // One clock cycle: called at a falling edge with inputs already applied.
  task automatic step();
    bit    free, tok;
    int    g;
    xfer_t x;
    #1;
    dut_g = bus.dllp_ready_o ? 1 : (bus.tlp_ready_o ? 2 : 0);
    if (rst) begin
      chk("rst_dllp_ready", bus.dllp_ready_o, 0);
      chk("rst_tlp_ready", bus.tlp_ready_o, 0);
      m_full = 0; m_streak = 0; exp_q.delete();
      acc_d = 0; acc_t = 0;
    end else begin
      chk("tx_valid", bus.tx_valid_o, m_full);
      free = !m_full || bus.tx_ready_i;
      tok  = bus.tlp_valid_i && !bus.tlp_block_i;
      g = 0;
      if (free) begin
        if (tok && m_streak == MAX) g = 2;
        else if (bus.dllp_valid_i)  g = 1;
        else if (tok)               g = 2;
      end
      chk("dllp_ready", bus.dllp_ready_o, g == 1);
      chk("tlp_ready", bus.tlp_ready_o, g == 2);
      if (g == 1) begin
        x.data = '0; x.data[DLLP_W-1:0] = bus.dllp_i; x.is_dllp = 1;
        exp_q.push_back(x);
        m_streak = tok ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
      end else if (g == 2) begin
        x.data = bus.tlp_i; x.is_dllp = 0;
        exp_q.push_back(x);
        m_streak = 0;
      end
      if (free) m_full = (g != 0);
      acc_d = (g == 1);
      acc_t = (g == 2);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.dllp_valid_i = 0; bus.tlp_valid_i = 0; bus.tlp_block_i = 0; bus.tx_ready_i = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    step(); step();
    rst = 0;
  endtask

  // Monitor: compares every PHY handshake against the expected queue.
  initial begin
    xfer_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.tx_valid_o && bus.tx_ready_i) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL mon_unexpected is_dllp=%0b data_lo=%h", bus.tx_is_dllp_o, bus.tx_data_o[63:0]);
        end else begin
          e = exp_q.pop_front();
          if (bus.tx_data_o !== e.data || bus.tx_is_dllp_o !== e.is_dllp) begin
            n_err++;
            $display("FAIL mon_xfer act is_dllp=%0b lo=%h exp is_dllp=%0b lo=%h",
                     bus.tx_is_dllp_o, bus.tx_data_o[63:0], e.is_dllp, e.data[63:0]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string            seq;
    logic [TLP_W-1:0] tv, ev;
    logic [DLLP_W-1:0] dv;
    rst = 1;
    bus.dllp_i = '0; bus.tlp_i = '0;
    idle_inputs();
    @(negedge clk);

    // Reset state
    do_reset();
    chk("reset_tx_valid", bus.tx_valid_o, 0);
    chk_w("reset_tx_data", bus.tx_data_o, '0);
    chk("reset_is_dllp", bus.tx_is_dllp_o, 0);

    // DLLP-only transfer
    bus.dllp_i = 48'hA5A5_0000_1234; bus.dllp_valid_i = 1;
    step();
    bus.dllp_valid_i = 0;
    ev = '0; ev[47:0] = 48'hA5A5_0000_1234;
    chk("dllp_only_valid", bus.tx_valid_o, 1);
    chk("dllp_only_is_dllp", bus.tx_is_dllp_o, 1);
    chk_w("dllp_only_data", bus.tx_data_o, ev);

    // Simultaneous requests: starvation guard every fifth grant
    do_reset();
    bus.dllp_valid_i = 1; bus.dllp_i = rand_dllp();
    bus.tlp_valid_i = 1;  bus.tlp_i = rand_tlp();
    seq = "";
    for (int i = 0; i < 10; i++) begin
      step();
      seq = {seq, gch(dut_g)};
      if (acc_d) bus.dllp_i = rand_dllp();
      if (acc_t) bus.tlp_i = rand_tlp();
    end
    chk_s("simul_grant_seq", seq, "DDDDTDDDDT");
`ifdef DLL_TX_SCHED_STATS_EN
    chk("stat_force", stat_force, 2);
    chk("stat_dllp", stat_dllp, 8);
    chk("stat_tlp", stat_tlp, 2);
`endif

    // Backpressure: TLP held stable, DLLP waits, then reloads without bubble
    bus.dllp_valid_i = 0;
    tv = rand_tlp(); bus.tlp_i = tv; bus.tlp_valid_i = 1;
    step();
    bus.tlp_valid_i = 0; bus.tx_ready_i = 0;
    dv = rand_dllp(); bus.dllp_i = dv; bus.dllp_valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_w("bp_data_stable", bus.tx_data_o, tv);
      chk("bp_is_dllp", bus.tx_is_dllp_o, 0);
    end
    bus.tx_ready_i = 1;
    step();
    chk("bp_dllp_granted", dut_g, 1);
    bus.dllp_valid_i = 0;
    ev = '0; ev[DLLP_W-1:0] = dv;
    chk("bp_reload_is_dllp", bus.tx_is_dllp_o, 1);
    chk_w("bp_reload_data", bus.tx_data_o, ev);

    // Block: TLP inhibited until tlp_block_i drops
    tv = rand_tlp(); bus.tlp_i = tv; bus.tlp_valid_i = 1; bus.tlp_block_i = 1;
    for (int i = 0; i < 3; i++) step();
    chk("blk_tx_valid", bus.tx_valid_o, 0);
    bus.tlp_block_i = 0;
    step();
    chk("blk_release_grant", dut_g, 2);
    bus.tlp_valid_i = 0;
    chk("blk_tx_valid_after", bus.tx_valid_o, 1);
    chk_w("blk_tx_data", bus.tx_data_o, tv);

    // Streak reset when the TLP request disappears for one DLLP grant
    bus.dllp_valid_i = 1; bus.dllp_i = rand_dllp();
    bus.tlp_valid_i = 1;  bus.tlp_i = rand_tlp();
    seq = "";
    for (int i = 0; i < 9; i++) begin
      bus.tlp_valid_i = (i != 3);
      step();
      seq = {seq, gch(dut_g)};
      if (acc_d) bus.dllp_i = rand_dllp();
      if (acc_t) bus.tlp_i = rand_tlp();
    end
    chk_s("streak_reset_seq", seq, "DDDDDDDDT");

    // Random traffic with requesters holding until accepted
    for (int i = 0; i < 3000; i++) begin
      if (!(bus.dllp_valid_i && !acc_d)) begin
        bus.dllp_valid_i = ($urandom_range(0, 9) < 5);
        bus.dllp_i = rand_dllp();
      end
      if (!(bus.tlp_valid_i && !acc_t)) begin
        bus.tlp_valid_i = ($urandom_range(0, 9) < 6);
        bus.tlp_i = rand_tlp();
      end
      bus.tlp_block_i = ($urandom_range(0, 9) < 2);
      bus.tx_ready_i  = ($urandom_range(0, 9) < 7);
      step();
    end

    // Drain; every expected transfer must have been observed
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    chk("drain_queue_empty", exp_q.size(), 0);

    // Reset while FULL and backpressured
    tv = rand_tlp(); bus.tlp_i = tv; bus.tlp_valid_i = 1;
    step();
    bus.tlp_valid_i = 0; bus.tx_ready_i = 0;
    step();
    chk("mid_full_before_rst", bus.tx_valid_o, 1);
    rst = 1; bus.dllp_valid_i = 1; bus.dllp_i = rand_dllp();
    step();
    chk("mid_rst_tx_valid", bus.tx_valid_o, 0);
    chk_w("mid_rst_tx_data", bus.tx_data_o, '0);
    chk("mid_rst_is_dllp", bus.tx_is_dllp_o, 0);
`ifdef DLL_TX_SCHED_STATS_EN
    chk("mid_rst_stat_dllp", stat_dllp, 0);
    chk("mid_rst_stat_tlp", stat_tlp, 0);
    chk("mid_rst_stat_force", stat_force, 0);
`endif
    rst = 0;
    step();
    chk("post_rst_dllp_grant", dut_g, 1);
    bus.dllp_valid_i = 0; bus.tx_ready_i = 1;
    for (int i = 0; i < 2; i++) step();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dll_tx_scheduler.md
Name: dll_tx_scheduler

Overview:
- Registered scheduler for the DLL transmit path.
- Shares the single PHY-facing TX slot between the DLLP generator (48-bit, Ack/Nak/UpdateFC) and the TLP path (1196-bit, sequence number plus LCRC framed).
- DLLPs win by default. A starvation guard forces a TLP grant after a programmable run of consecutive DLLP grants.
- Provides valid/ready handshakes on both requesters and on the PHY side, with full throughput and 1-cycle latency.

Parameters:
- MAX_DLLP_STREAK, 4, consecutive DLLP grants allowed while a TLP is waiting before the TLP is forced (range 1..15).
- STAT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- dllp_i  input  48  DLLP payload
- dllp_valid_i  input  1  DLLP request
- dllp_ready_o  output  1  DLLP accepted this cycle when high together with dllp_valid_i
- tlp_i  input  1196  framed TLP
- tlp_valid_i  input  1  TLP request
- tlp_ready_o  output  1  TLP accepted this cycle when high together with tlp_valid_i
- tlp_block_i  input  1  inhibit TLP grants (replay in progress or link not DL_Active); DLLPs unaffected
- tx_data_o  output  1196  data to PHY
- tx_is_dllp_o  output  1  1 = tx_data_o holds a DLLP in bits [47:0]
- tx_valid_o  output  1  output slot full
- tx_ready_i  input  1  PHY accepts the slot this cycle

Behaviour:
- Reset (rst=1 at a clk edge): tx_valid_o=0, tx_data_o=0, tx_is_dllp_o=0, streak=0.
  - dllp_ready_o and tlp_ready_o are 0 while rst is high.
  - Reset mid-transfer drops the held slot; nothing is replayed by this block.
- Slot states: EMPTY (tx_valid_o=0) and FULL (tx_valid_o=1).
  - free = EMPTY, or FULL with tx_ready_i=1 (pipelined reload, no bubble).
- Grant (combinational, evaluated when free=1):
  - force_tlp = tlp_valid_i && !tlp_block_i && streak==MAX_DLLP_STREAK.
  - If force_tlp: grant TLP.
  - Else if dllp_valid_i: grant DLLP.
  - Else if tlp_valid_i && !tlp_block_i: grant TLP.
  - Else: no grant.
- Ready outputs: dllp_ready_o = free && grant==DLLP; tlp_ready_o = free && grant==TLP. Both are never high in the same cycle.
- Load on grant, visible on the next edge:
  - DLLP grant: tx_data_o = {1148'b0, dllp_i}, tx_is_dllp_o=1.
  - TLP grant: tx_data_o = tlp_i, tx_is_dllp_o=0.
  - tx_valid_o=1 in both cases.
- Free with no grant: tx_valid_o goes to 0. tx_data_o and tx_is_dllp_o hold their values (don't-care).
- FULL with tx_ready_i=0: all outputs hold bit-stable. Both ready outputs are 0.
- Streak counter (4-bit):
  - DLLP grant with tlp_valid_i && !tlp_block_i: streak = min(streak+1, MAX_DLLP_STREAK).
  - DLLP grant otherwise: streak = 0.
  - TLP grant: streak = 0.
  - No grant: streak holds.
  - Assertion of tlp_block_i does not by itself clear streak.
- Requester rule: once valid is high, payload and valid stay stable until accepted. A requester may not retract.
- Latency: requester accept to tx_valid_o is 1 cycle. Sustained throughput is 1 transfer per clk while tx_ready_i=1.

Optional Feature:
- Macro DLL_TX_SCHED_STATS_EN.
- When defined, adds outputs stat_dllp_o, stat_tlp_o, and stat_force_o (each STAT_W bits).
  - These count DLLP grants, TLP grants, and forced TLP grants respectively.
  - They wrap modulo 2^STAT_W and are cleared by rst.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- dll_pkg holds: DLLP_W=48, TLP_W=1196, enum tx_grant_t {GNT_NONE, GNT_DLLP, GNT_TLP}.
- One natural sub-module: dll_tx_slot, the single-entry output register with valid/ready and reload-on-accept. The scheduler instantiates it and drives its load strobe and data mux.

Test Plan:
- DLLP-only: dllp_i=48'hA5A5_0000_1234 valid with tx_ready_i=1 -> next cycle tx_valid_o=1, tx_is_dllp_o=1, tx_data_o[47:0]=48'hA5A5_0000_1234, upper bits 0.
- Simultaneous requests, MAX_DLLP_STREAK=4, both always valid, tx_ready_i=1 -> grant sequence D,D,D,D,T,D,D,D,D,T; stat_force_o=2 after 10 cycles (with the feature enabled).
- Backpressure: TLP loaded, tx_ready_i=0 for 5 cycles with dllp_valid_i=1 -> tx_data_o stable, dllp_ready_o=0 throughout; DLLP loaded in the same cycle tx_ready_i returns to 1.
- Block: tlp_block_i=1, tlp_valid_i=1, no DLLPs -> tlp_ready_o=0 and tx_valid_o=0; deassert tlp_block_i -> TLP granted 1 cycle later.
- Streak reset: 3 DLLP grants with TLP pending, then tlp_valid_i drops for one DLLP grant -> streak=0; next pending TLP waits for 4 more DLLPs.
- Reset mid-operation: rst=1 while FULL and tx_ready_i=0 -> next edge tx_valid_o=0, tx_data_o=0, ready outputs 0, counters 0.
